// File: rtl/nasti_sram_writer_pkg.sv
// Shared encodings for the NASTI SRAM write slave: response codes, burst types, FSM states.
package nasti_sram_writer_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_t;

endpackage

// File: rtl/nasti_sram_writer.sv
// NASTI write-channel slave: accepts one AW/W burst at a time, writes each beat into a
// single-port SRAM, and answers with a B response that flags range or encoding errors.
module nasti_sram_writer
   import nasti_sram_writer_pkg::*;
#(
   parameter int                    ID_WIDTH   = 1,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    USER_WIDTH = 1,
   parameter int                    MEM_AW     = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]              aw_len,
   input  logic [2:0]              aw_size,
   input  logic [1:0]              aw_burst,
   input  logic [USER_WIDTH-1:0]   aw_user,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_last,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp,
   output logic [USER_WIDTH-1:0]   b_user,
   output logic                    b_valid,
   input  logic                    b_ready,
   output logic                    mem_we,
   output logic [MEM_AW-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int BSHIFT = $clog2(BYTES);
   // Extra headroom bits so the end-of-burst sum can never wrap before the compare.
   localparam int EW     = ADDR_WIDTH + 16;
   localparam logic [EW-1:0] BASE_EXT = EW'(BASE_ADDR);
   localparam logic [EW-1:0] LIMIT    = BASE_EXT + (EW'(1) << (MEM_AW + BSHIFT)) - EW'(1);

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $fatal(1, "nasti_sram_writer: DATA_WIDTH must be 32 or 64");
   end
   if (USER_WIDTH < 1) begin : g_bad_user_width
      $fatal(1, "nasti_sram_writer: USER_WIDTH must be positive");
   end

   // Decode errors (outside the window) take priority over unsupported encodings.
   function automatic logic [1:0] check_aw(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [7:0]            len,
                                           input logic [2:0]            size,
                                           input logic [1:0]            burst);
      logic [EW-1:0] last_byte;
      last_byte = EW'(addr) + (EW'(len) << size);
      if (EW'(addr) < BASE_EXT || last_byte > LIMIT)
         return RESP_DECERR;
      if ((burst != BURST_FIXED && burst != BURST_INCR) || int'(size) > BSHIFT)
         return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH-1:0]   offset;
   logic [7:0]              len_q;
   logic [7:0]              beat_cnt;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [1:0]              err_q;
   logic                    last_err;
   logic                    w_hs;
   logic                    final_beat;
   logic                    last_bad;

   // err_q gates the SRAM strobe; a w_last mismatch only taints the response.
   assign w_hs       = w_valid && w_ready;
   assign final_beat = (beat_cnt == len_q);
   assign last_bad   = (w_last != final_beat);
   assign offset     = cur_addr - BASE_ADDR;
   assign mem_addr   = MEM_AW'(offset >> BSHIFT);
   assign mem_we     = w_hs && (err_q == RESP_OKAY);
   assign mem_wdata  = w_data;
   assign mem_be     = w_strb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         aw_ready <= 1'b1;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
         b_id     <= '0;
         b_user   <= '0;
         cur_addr <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         size_q   <= '0;
         burst_q  <= BURST_FIXED;
         err_q    <= RESP_OKAY;
         last_err <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (aw_valid && aw_ready) begin
                  b_id     <= aw_id;
                  b_user   <= aw_user;
                  cur_addr <= aw_addr;
                  len_q    <= aw_len;
                  size_q   <= aw_size;
                  burst_q  <= aw_burst;
                  beat_cnt <= '0;
                  err_q    <= check_aw(aw_addr, aw_len, aw_size, aw_burst);
                  last_err <= 1'b0;
                  aw_ready <= 1'b0;
                  w_ready  <= 1'b1;
                  state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (burst_q == BURST_INCR)
                     cur_addr <= cur_addr + (ADDR_WIDTH'(1) << size_q);
                  if (final_beat) begin
                     w_ready <= 1'b0;
                     b_valid <= 1'b1;
                     if (err_q != RESP_OKAY)
                        b_resp <= err_q;
                     else if (last_err || last_bad)
                        b_resp <= RESP_SLVERR;
                     else
                        b_resp <= RESP_OKAY;
                     state   <= ST_RESP;
                  end else if (last_bad) begin
                     last_err <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               if (b_ready) begin
                  b_valid  <= 1'b0;
                  aw_ready <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               aw_ready <= 1'b1;
               w_ready  <= 1'b0;
               b_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nasti_sram_writer.sv
// Scoreboard bench for nasti_sram_writer: expected SRAM writes and B responses are queued
// as stimulus is driven and compared when the DUT strobes mem_we or completes B.
module tb_nasti_sram_writer;

   localparam logic [15:0] BASE = 16'h1000;
   localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
   localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
   localparam int          LIMIT_CYC = 50;

   typedef struct {
      logic [9:0]  addr;
      logic [63:0] data;
      logic [7:0]  be;
   } wr_t;

   typedef struct {
      logic [1:0] resp;
      logic       id;
      logic       user;
   } bresp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        aw_id, aw_user, aw_valid, aw_ready;
   logic [15:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last, w_valid, w_ready;
   logic        b_id, b_user, b_valid, b_ready;
   logic [1:0]  b_resp;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;

   wr_t    wq[$];
   bresp_t bq[$];
   int     vectors = 0;
   int     miscompares = 0;

   nasti_sram_writer #(
      .ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(64), .USER_WIDTH(1),
      .MEM_AW(10), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
      .aw_burst(aw_burst), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Pop and compare whenever the DUT writes SRAM or completes a B handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            if (wq.size() == 0) begin
               checkOutput("unexpected_mem_we", {54'd0, mem_addr}, 64'hFFFF);
            end else begin
               wr_t e;
               e = wq.pop_front();
               checkOutput("mem_addr", {54'd0, mem_addr}, {54'd0, e.addr});
               checkOutput("mem_wdata", mem_wdata, e.data);
               checkOutput("mem_be", {56'd0, mem_be}, {56'd0, e.be});
            end
         end
         if (b_valid && b_ready) begin
            if (bq.size() == 0) begin
               checkOutput("unexpected_b", {62'd0, b_resp}, 64'hFFFF);
            end else begin
               bresp_t e;
               e = bq.pop_front();
               checkOutput("b_resp", {62'd0, b_resp}, {62'd0, e.resp});
               checkOutput("b_id", {63'd0, b_id}, {63'd0, e.id});
               checkOutput("b_user", {63'd0, b_user}, {63'd0, e.user});
            end
         end
      end
   end

   task automatic driveAw(input logic id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic user);
      int n = 0;
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
      aw_user = user; aw_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!aw_ready && n < LIMIT_CYC);
      if (!aw_ready) checkOutput("aw_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 aw_valid = 1'b0;
   endtask

   task automatic driveBeat(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!w_ready && n < LIMIT_CYC);
      if (!w_ready) checkOutput("w_timeout", 64'd0, 64'd1);
      checkOutput("aw_ready_busy", {63'd0, aw_ready}, 64'd0);
      @(posedge clk);
      #1 w_valid = 1'b0;
   endtask

   // One full burst: queue expectations, drive AW and every beat, then hold and take B.
   task automatic applyStimulus(input logic id, input logic [15:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic user,
                                input int lastBeat, input logic [7:0] strb,
                                input logic [1:0] expResp, input bit expWrite, input int bHold);
      logic [9:0] word;
      int         n = 0;
      bq.push_back('{resp: expResp, id: id, user: user});
      word = 10'((addr - BASE) >> 3);
      driveAw(id, addr, len, size, burst, user);
      for (int i = 0; i <= int'(len); i++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         if (expWrite)
            wq.push_back('{addr: (burst == INCR) ? word + 10'(i) : word, data: d, be: strb});
         driveBeat(d, strb, i == lastBeat);
      end
      @(negedge clk);
      checkOutput("b_latency", {63'd0, b_valid}, 64'd1);
      repeat (bHold) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("b_hold_valid", {63'd0, b_valid}, 64'd1);
         checkOutput("b_hold_resp", {62'd0, b_resp}, {62'd0, expResp});
      end
      @(posedge clk);
      #1 b_ready = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!b_valid && n < LIMIT_CYC);
      if (!b_valid) checkOutput("b_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 b_ready = 1'b0;
      checkOutput("aw_ready_after_b", {63'd0, aw_ready}, 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      aw_valid = 1'b0; aw_id = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0;
      aw_burst = '0; aw_user = 1'b0;
      w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_aw_ready", {63'd0, aw_ready}, 64'd1);
      checkOutput("rst_w_ready", {63'd0, w_ready}, 64'd0);
      checkOutput("rst_b_valid", {63'd0, b_valid}, 64'd0);
      checkOutput("rst_mem_we", {63'd0, mem_we}, 64'd0);
      checkOutput("rst_b_resp", {62'd0, b_resp}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, BASE + 16'h0010, 8'd3, 3'd3, INCR,  1'b1, 3, 8'hFF, OKAY,   1'b1, 0);
      applyStimulus(1'b0, BASE + 16'h0008, 8'd1, 3'd3, FIXED, 1'b0, 1, 8'h3C, OKAY,   1'b1, 0);
      applyStimulus(1'b1, BASE + 16'h1FF8, 8'd1, 3'd3, INCR,  1'b0, 1, 8'hFF, DECERR, 1'b0, 0);
      applyStimulus(1'b0, BASE + 16'h0040, 8'd3, 3'd3, WRAP,  1'b1, 3, 8'hFF, SLVERR, 1'b0, 0);
      applyStimulus(1'b1, BASE + 16'h0100, 8'd2, 3'd3, INCR,  1'b0, 1, 8'hFF, SLVERR, 1'b1, 5);
      applyStimulus(1'b0, BASE - 16'h0008, 8'd0, 3'd3, INCR,  1'b0, 0, 8'hFF, DECERR, 1'b0, 0);
      applyStimulus(1'b1, 16'hFFF8,        8'd1, 3'd3, INCR,  1'b1, 1, 8'hFF, DECERR, 1'b0, 0);
      applyStimulus(1'b0, BASE + 16'h0020, 8'd1, 3'd4, INCR,  1'b0, 1, 8'hFF, SLVERR, 1'b0, 0);
      applyStimulus(1'b1, BASE + 16'h1FF8, 8'd0, 3'd3, INCR,  1'b1, 0, 8'h81, OKAY,   1'b1, 1);

      // Reset lands while the third beat of an eight-beat burst is on the bus.
      bq.delete();
      driveAw(1'b1, BASE, 8'd7, 3'd3, INCR, 1'b1);
      for (int i = 0; i < 2; i++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         wq.push_back('{addr: 10'(i), data: d, be: 8'hFF});
         driveBeat(d, 8'hFF, 1'b0);
      end
      w_data = 64'hDEAD_BEEF_0000_0002; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_mid_mem_we", {63'd0, mem_we}, 64'd0);
      checkOutput("rst_mid_aw_ready", {63'd0, aw_ready}, 64'd1);
      checkOutput("rst_mid_b_valid", {63'd0, b_valid}, 64'd0);
      w_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("rst_mid_wq_drained", 64'(wq.size()), 64'd0);

      applyStimulus(1'b0, BASE + 16'h0200, 8'd2, 3'd3, INCR, 1'b0, 2, 8'hFF, OKAY, 1'b1, 0);
      applyStimulus(1'b1, BASE,            8'd255, 3'd3, INCR, 1'b1, 255, 8'hFF, OKAY, 1'b1, 0);

      repeat (2) @(posedge clk);
      checkOutput("wq_drained", 64'(wq.size()), 64'd0);
      checkOutput("bq_drained", 64'(bq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
